fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised instruction-fetch stage with a decoupled prefetch queue. It holds the PC, issues sequential requests to instruction memory over a valid/ready handshake, and tolerates variable in-order memory latency. Fetched instructions are buffered with their PCs in a DEPTH-entry queue feeding decode. A taken branch redirects the PC, flushes the queue and discards stale in-flight responses; this extends the single-cycle fetch (mux, PC register, +4 adder) with stall, buffering and latency tolerance.

## Interface
- ADDR_W, 64, PC and memory address width
- INSTR_W, 32, instruction width
- DEPTH, 4, prefetch queue entries (power of two, ≥2); also the maximum number of outstanding requests
- RESET_PC, 0, PC value loaded by reset
- PC_STEP, 4, sequential PC increment
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- PCSrc_F  in  1  redirect strobe (taken branch); single-cycle pulse
- PCBranch_F  in  ADDR_W  redirect target, sampled when PCSrc_F=1
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_addr_F  out  ADDR_W  request address (current PC)
- imem_rsp_valid  in  1  response valid; no backpressure; responses arrive in request order
- imem_rsp_data  in  INSTR_W  fetched instruction
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head; low = stall
- out_instr  out  INSTR_W  head instruction
- out_pc  out  ADDR_W  PC of head instruction

## Operation
- State: PC register, a DEPTH-entry in-flight address FIFO, a DEPTH-entry {pc, instr} queue, an outstanding counter `outst` (0..DEPTH), and a discard counter `drop` (0..DEPTH).
- Credit rule: imem_req_valid = !PCSrc_F && (count + outst < DEPTH). This guarantees every response has a queue slot.
- Request fire (valid && ready): push PC into the address FIFO, increment outst, set PC to PC + PC_STEP (modulo 2^ADDR_W, silent wrap).
- Response with drop>0: pop the address FIFO, decrement outst and drop, discard the data.
- Response with drop=0: pop the address FIFO, decrement outst, enqueue {popped pc, imem_rsp_data}.
- Dequeue when out_valid && out_ready. Enqueue and dequeue may occur in the same cycle; count is unchanged.
- Redirect (PCSrc_F=1) has highest priority:
  - PC is set to PCBranch_F.
  - The queue is emptied.
  - drop is set to outst − imem_rsp_valid. Every request still in flight becomes stale.
  - A response arriving in the redirect cycle is discarded.
  - No request is issued and no dequeue occurs in that cycle.
- A redirect while drop>0 recomputes drop by the same rule. Stale responses from both generations are discarded.
- out_valid = (count != 0) && !PCSrc_F.

## Timing
- Reset (asynchronous assert):
  - PC=RESET_PC; queue and address FIFO empty; outst=0, drop=0.
  - out_valid=0, imem_req_valid=0.
  - out_instr and out_pc read 0.
- First cycle after reset release: imem_req_valid=1, imem_addr_F=RESET_PC.
- Reset asserted mid-operation drops all queued and in-flight work. Responses arriving after reset release for pre-reset requests are illegal; the memory must be reset together with this block.
- Minimum latency: request fires in cycle N, response in N+1, out_valid in N+2 (the queue is registered, with no bypass).
- Zero-wait memory with out_ready=1: one instruction per cycle, sustained.
- With DEPTH outstanding or a full queue, imem_req_valid=0 until a response or dequeue frees a credit.
- The first request after a redirect issues in the cycle following PCSrc_F, with address PCBranch_F.

## Configuration
- FETCH_PERF_EN defined: adds two outputs, perf_fetched (32 bits, counts enqueued instructions) and perf_redirects (32 bits, counts PCSrc_F pulses).
  - Both reset to 0 and wrap silently.
  - Responses discarded under drop are not counted.
- FETCH_PERF_EN undefined: both ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset release, memory always ready, 1-cycle latency, out_ready=1 → imem_addr 0,4,8,…; out_pc 0,4,8 starting two cycles after the first fire; one instruction per cycle.
- out_ready=0 with DEPTH=4 → exactly 4 requests issue, queue fills, imem_req_valid=0; raising out_ready drains in order with PCs 0,4,8,C, then fetching resumes at 0x10.
- 3-cycle memory latency, redirect to 0x100 while 2 requests are outstanding → those 2 responses are discarded; out_pc next shows 0x100; no stale instruction reaches the output.
- Redirect in the same cycle as a response and a ready request → response dropped, no request that cycle, out_valid=0, next imem_addr=0x100.
- RESET_PC=0xFFFF_FFFF_FFFF_FFFC → second request address is 0x0 (wrap).
- Assert reset mid-stream with a full queue → out_valid and imem_req_valid are 0 immediately (asynchronously); restart at RESET_PC; with FETCH_PERF_EN, counters read 0.

Source files
------------

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: handshake bundle of the fetch stage.
//   imem_req_valid/imem_req_ready/imem_addr_F : request channel to instruction memory
//   imem_rsp_valid/imem_rsp_data              : in-order response channel (no backpressure)
//   out_valid/out_ready/out_instr/out_pc      : queue head towards decode
// master = fetch stage side, slave = memory/decode side.
interface fetch_queue_if #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
);
  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [ADDR_W-1:0]  imem_addr_F;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;

  modport master (
    output imem_req_valid, imem_addr_F, out_valid, out_instr, out_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr_F, out_valid, out_instr, out_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage with a decoupled prefetch queue.
// Holds the PC, issues sequential requests, tolerates variable in-order
// memory latency and buffers {pc, instr} pairs for decode. A taken branch
// redirects the PC, flushes the queue and discards stale in-flight responses.
// Ports:
//   clk, reset (async, active low)
//   PCSrc_F / PCBranch_F : redirect strobe and target
//   bus                  : fetch_queue_if.master (imem request/response, decode output)
//   perf_fetched, perf_redirects : only when FETCH_PERF_EN is defined
module fetch_queue #(
  parameter int                ADDR_W   = 64,
  parameter int                INSTR_W  = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PCSrc_F,
  input  logic [ADDR_W-1:0] PCBranch_F,
  fetch_queue_if.master     bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_redirects
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] pc;

  // in-flight address FIFO: pairs each response with the PC it was fetched from
  logic [ADDR_W-1:0] af_mem [DEPTH];
  logic [PW-1:0]     af_wp, af_rp;
  logic [CW-1:0]     outst;
  logic [CW-1:0]     drop;

  // {pc, instr} queue towards decode
  entry_t            q_mem [DEPTH];
  logic [PW-1:0]     q_wp, q_rp;
  logic [CW-1:0]     count;

  logic [CW:0]       inuse;
  logic              credit, req_valid, req_fire, rsp, enq, deq, out_v;

  // A request only issues if its response is guaranteed a queue slot.
  assign inuse     = {1'b0, count} + {1'b0, outst};
  assign credit    = inuse < (CW+1)'(DEPTH);
  // Gated by reset so the request strobe drops as soon as reset asserts.
  assign req_valid = reset && !PCSrc_F && credit;
  assign req_fire  = req_valid && bus.imem_req_ready;
  assign rsp       = bus.imem_rsp_valid;
  assign enq       = rsp && !PCSrc_F && (drop == '0);
  assign out_v     = (count != '0) && !PCSrc_F;
  assign deq       = out_v && bus.out_ready;

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr_F    = pc;
  assign bus.out_valid      = out_v;
  assign bus.out_instr      = q_mem[q_rp].instr;
  assign bus.out_pc         = q_mem[q_rp].pc;

  // Address storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (req_fire) af_mem[af_wp] <= pc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc    <= RESET_PC;
      af_wp <= '0;
      af_rp <= '0;
      outst <= '0;
      drop  <= '0;
      q_wp  <= '0;
      q_rp  <= '0;
      count <= '0;
      // head reads zero out of reset
      for (int i = 0; i < DEPTH; i++) q_mem[i] <= '0;
    end else begin
      if (req_fire) af_wp <= af_wp + 1'b1;
      if (rsp)      af_rp <= af_rp + 1'b1;
      outst <= outst + CW'(req_fire) - CW'(rsp);

      if (PCSrc_F) begin
        pc    <= PCBranch_F;
        q_wp  <= '0;
        q_rp  <= '0;
        count <= '0;
        // everything still in flight after this cycle is stale
        drop  <= outst - CW'(rsp);
      end else begin
        if (req_fire) pc <= pc + ADDR_W'(PC_STEP);
        if (rsp && drop != '0) drop <= drop - 1'b1;
        if (enq) begin
          q_mem[q_wp] <= '{pc: af_mem[af_rp], instr: bus.imem_rsp_data};
          q_wp        <= q_wp + 1'b1;
        end
        if (deq) q_rp <= q_rp + 1'b1;
        count <= count + CW'(enq) - CW'(deq);
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched   <= '0;
      perf_redirects <= '0;
    end else begin
      if (enq)     perf_fetched   <= perf_fetched + 32'd1;
      if (PCSrc_F) perf_redirects <= perf_redirects + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: table-driven directed vectors, hand sequences for reset,
// PC wrap and mid-stream reset, then randomized traffic against a
// queue-based reference model with a latency-modelling memory.
module tb_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pcsrc = 1'b0;
  logic [63:0] tgt = '0;
  logic        pcsrc2 = 1'b0;
  logic [63:0] tgt2 = '0;

  always #5 clk = ~clk;

  fetch_queue_if #(.ADDR_W(64), .INSTR_W(32)) bus ();
  fetch_queue_if #(.ADDR_W(64), .INSTR_W(32)) bus2 ();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_f, perf_r, p2f, p2r;
`endif

  fetch_queue #(.ADDR_W(64), .INSTR_W(32), .DEPTH(DEPTH), .RESET_PC(64'h0), .PC_STEP(4)) dut (
    .clk(clk), .reset(reset), .PCSrc_F(pcsrc), .PCBranch_F(tgt), .bus(bus)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_f), .perf_redirects(perf_r)
`endif
  );

  // second instance only exercises PC wrap-around
  fetch_queue #(.ADDR_W(64), .INSTR_W(32), .DEPTH(DEPTH),
                .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .PC_STEP(4)) dut2 (
    .clk(clk), .reset(reset), .PCSrc_F(pcsrc2), .PCBranch_F(tgt2), .bus(bus2)
`ifdef FETCH_PERF_EN
    , .perf_fetched(p2f), .perf_redirects(p2r)
`endif
  );

  // ---------------- reference model ----------------
  typedef struct { logic [63:0] addr; int due; } mreq_t;
  typedef struct { logic [63:0] addr; int gen; } infl_t;
  typedef struct { logic [63:0] pc; logic [31:0] instr; } ent_t;

  mreq_t       mem_q[$];
  infl_t       infl[$];
  ent_t        fq[$];
  logic [63:0] m_pc;
  int          gen, cyc, lat;
  int          m_fetched, m_redirects;
  int          nchecks = 0, nerr = 0;

  logic        s_rv, s_ov;
  logic [63:0] s_addr, s_pc;

  function automatic logic [31:0] instr_of(logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h9E37_79B9;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One cycle: drive memory response, sample outputs, check against the
  // model, advance the model, then wait for the next negedge.
  task automatic step();
    logic        rv, e_rv, e_ov, fire, deq;
    logic [63:0] ra;
    int          d;
    infl_t       f;
    rv = 1'b0; ra = '0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      rv = 1'b1; ra = mem_q[0].addr; void'(mem_q.pop_front());
    end
    bus.imem_rsp_valid = rv;
    bus.imem_rsp_data  = rv ? instr_of(ra) : 32'hDEAD_BEEF;
    #1;
    e_rv = !pcsrc && ((fq.size() + infl.size()) < DEPTH);
    e_ov = !pcsrc && (fq.size() > 0);
    s_rv = bus.imem_req_valid; s_addr = bus.imem_addr_F;
    s_ov = bus.out_valid;      s_pc   = bus.out_pc;
    chk("req_valid", 64'(s_rv), 64'(e_rv));
    chk("imem_addr", s_addr, m_pc);
    chk("out_valid", 64'(s_ov), 64'(e_ov));
    if (e_ov) begin
      chk("out_pc", s_pc, fq[0].pc);
      chk("out_instr", 64'(bus.out_instr), 64'(fq[0].instr));
    end
`ifdef FETCH_PERF_EN
    chk("perf_fetched", 64'(perf_f), 64'(m_fetched));
    chk("perf_redirects", 64'(perf_r), 64'(m_redirects));
`endif
    fire = e_rv && bus.imem_req_ready;
    deq  = e_ov && bus.out_ready;
    if (deq) void'(fq.pop_front());
    if (rv) begin
      f = infl.pop_front();
      if (!pcsrc && f.gen == gen) begin
        fq.push_back('{pc: f.addr, instr: instr_of(f.addr)});
        m_fetched++;
      end
    end
    if (pcsrc) begin
      fq.delete(); gen++; m_pc = tgt; m_redirects++;
    end else if (fire) begin
      d = cyc + lat;
      if (mem_q.size() > 0 && mem_q[$].due >= d) d = mem_q[$].due + 1;
      mem_q.push_back('{addr: s_addr, due: d});
      infl.push_back('{addr: m_pc, gen: gen});
      m_pc = m_pc + 64'd4;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    pcsrc = 1'b0; tgt = '0;
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = '0; bus.out_ready = 1'b0;
    mem_q.delete(); infl.delete(); fq.delete();
    m_pc = 64'h0; gen = 0; m_fetched = 0; m_redirects = 0;
    #1;
    chk("rst out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst req_valid", 64'(bus.imem_req_valid), 64'(0));
    chk("rst out_pc", bus.out_pc, 64'h0);
    chk("rst out_instr", 64'(bus.out_instr), 64'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int rst, pcsrc; logic [63:0] tgt; int rdy, ordy, lat;
    int e_rv; logic [63:0] e_addr; int e_ov; logic [63:0] e_pc;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t V(int rst, int pc_s, logic [63:0] t, int rdy, int ordy, int l,
                             int erv, logic [63:0] ea, int eov, logic [63:0] ep);
    vec_t v;
    v.rst = rst; v.pcsrc = pc_s; v.tgt = t; v.rdy = rdy; v.ordy = ordy; v.lat = l;
    v.e_rv = erv; v.e_addr = ea; v.e_ov = eov; v.e_pc = ep;
    return v;
  endfunction

  initial begin
    bus2.imem_req_ready = 1'b1; bus2.imem_rsp_valid = 1'b0;
    bus2.imem_rsp_data = '0;    bus2.out_ready = 1'b0;
    lat = 1; cyc = 0;

    // streaming, 1-cycle memory, decode always ready
    vecs.push_back(V(1,0,64'h0,1,1,1, 1,64'h00,0,64'h0));
    vecs.push_back(V(0,0,64'h0,1,1,1, 1,64'h04,0,64'h0));
    vecs.push_back(V(0,0,64'h0,1,1,1, 1,64'h08,1,64'h0));
    vecs.push_back(V(0,0,64'h0,1,1,1, 1,64'h0C,1,64'h4));
    vecs.push_back(V(0,0,64'h0,1,1,1, 1,64'h10,1,64'h8));
    // decode stalled: four requests fill the queue, then drain in order
    vecs.push_back(V(1,0,64'h0,1,0,1, 1,64'h00,0,64'h0));
    vecs.push_back(V(0,0,64'h0,1,0,1, 1,64'h04,0,64'h0));
    vecs.push_back(V(0,0,64'h0,1,0,1, 1,64'h08,1,64'h0));
    vecs.push_back(V(0,0,64'h0,1,0,1, 1,64'h0C,1,64'h0));
    vecs.push_back(V(0,0,64'h0,1,0,1, 0,64'h10,1,64'h0));
    vecs.push_back(V(0,0,64'h0,1,0,1, 0,64'h10,1,64'h0));
    vecs.push_back(V(0,0,64'h0,1,1,1, 0,64'h10,1,64'h0));
    vecs.push_back(V(0,0,64'h0,1,1,1, 1,64'h10,1,64'h4));
    vecs.push_back(V(0,0,64'h0,1,1,1, 1,64'h14,1,64'h8));
    vecs.push_back(V(0,0,64'h0,1,1,1, 1,64'h18,1,64'hC));
    vecs.push_back(V(0,0,64'h0,1,1,1, 1,64'h1C,1,64'h10));
    // 3-cycle memory, redirect with two requests outstanding
    vecs.push_back(V(1,0,64'h0,  1,1,3, 1,64'h000,0,64'h0));
    vecs.push_back(V(0,0,64'h0,  1,1,3, 1,64'h004,0,64'h0));
    vecs.push_back(V(0,1,64'h100,1,1,3, 0,64'h008,0,64'h0));
    vecs.push_back(V(0,0,64'h0,  1,1,3, 1,64'h100,0,64'h0));
    vecs.push_back(V(0,0,64'h0,  1,1,3, 1,64'h104,0,64'h0));
    vecs.push_back(V(0,0,64'h0,  1,1,3, 1,64'h108,0,64'h0));
    vecs.push_back(V(0,0,64'h0,  1,1,3, 1,64'h10C,0,64'h0));
    vecs.push_back(V(0,0,64'h0,  1,1,3, 0,64'h110,1,64'h100));
    vecs.push_back(V(0,0,64'h0,  1,1,3, 1,64'h110,1,64'h104));
    // redirect coinciding with a response and a ready memory
    vecs.push_back(V(1,0,64'h0,  1,1,1, 1,64'h000,0,64'h0));
    vecs.push_back(V(0,1,64'h100,1,1,1, 0,64'h004,0,64'h0));
    vecs.push_back(V(0,0,64'h0,  1,1,1, 1,64'h100,0,64'h0));
    vecs.push_back(V(0,0,64'h0,  1,1,1, 1,64'h104,0,64'h0));
    vecs.push_back(V(0,0,64'h0,  1,1,1, 1,64'h108,1,64'h100));

    foreach (vecs[i]) begin
      if (vecs[i].rst != 0) do_reset();
      pcsrc = (vecs[i].pcsrc != 0);
      tgt   = vecs[i].tgt;
      bus.imem_req_ready = (vecs[i].rdy != 0);
      bus.out_ready      = (vecs[i].ordy != 0);
      lat   = vecs[i].lat;
      step();
      chk($sformatf("vec%0d req_valid", i), 64'(s_rv), 64'(vecs[i].e_rv));
      chk($sformatf("vec%0d imem_addr", i), s_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d out_valid", i), 64'(s_ov), 64'(vecs[i].e_ov));
      if (vecs[i].e_ov != 0) chk($sformatf("vec%0d out_pc", i), s_pc, vecs[i].e_pc);
    end
    pcsrc = 1'b0;

    // PC wrap: second request of the high RESET_PC instance is at 0
    do_reset();
    #1;
    chk("wrap first addr", bus2.imem_addr_F, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap first valid", 64'(bus2.imem_req_valid), 64'(1));
    chk("wrap out_valid", 64'(bus2.out_valid), 64'(0));
    chk("wrap out_pc", bus2.out_pc, 64'h0);
    chk("wrap out_instr", 64'(bus2.out_instr), 64'h0);
`ifdef FETCH_PERF_EN
    chk("wrap perf", 64'(p2f) + 64'(p2r), 64'h0);
`endif
    @(negedge clk);
    #1;
    chk("wrap second addr", bus2.imem_addr_F, 64'h0);

    // reset asserted mid-stream with a full queue
    do_reset();
    bus.imem_req_ready = 1'b1; bus.out_ready = 1'b0; lat = 1;
    repeat (6) step();
    chk("full before reset", 64'(s_ov), 64'(1));
    #2;
    reset = 1'b0;
    #1;
    chk("async out_valid", 64'(bus.out_valid), 64'(0));
    chk("async req_valid", 64'(bus.imem_req_valid), 64'(0));
`ifdef FETCH_PERF_EN
    chk("async perf_fetched", 64'(perf_f), 64'h0);
    chk("async perf_redirects", 64'(perf_r), 64'h0);
`endif
    do_reset();
    bus.imem_req_ready = 1'b1; bus.out_ready = 1'b1;
    step();
    chk("restart valid", 64'(s_rv), 64'(1));
    chk("restart addr", s_addr, 64'h0);

    // randomized traffic against the reference model
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      pcsrc = ($urandom_range(0, 19) == 0);
      tgt   = {32'($urandom), 32'($urandom)} & ~64'h3;
      bus.imem_req_ready = ($urandom_range(0, 3) != 0);
      bus.out_ready      = ($urandom_range(0, 2) != 0);
      lat   = 1 + $urandom_range(0, 3);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule
